// File: rtl/regfile_rd2w1.sv
// Two-read, one-write register file with a falling-edge datapath, registered
// reads with write-through bypass, and a sequencer that zeroes every entry.
module regfile_rd2w1 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              rd_load;
  logic              rvalid_next;
  logic              wr_drop_next;
  logic [WIDTH-1:0]  rd_a_val, rd_b_val;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    mem_we       = 1'b0;
    mem_waddr    = waddr;
    mem_wdata    = wdata;
    rd_load      = 1'b0;
    rvalid_next  = 1'b0;
    wr_drop_next = 1'b0;
    case (state_reg)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = idx_reg;
        mem_wdata    = '0;
        idx_next     = idx_reg + 1'b1;
        wr_drop_next = we;
        if (idx_reg == {ADDR_W{1'b1}})
          state_next = IDLE;
      end
      default: begin
        if (clr) begin
          state_next   = CLEAR;
          idx_next     = '0;
          wr_drop_next = we;
        end else begin
          mem_we      = we && (waddr != '0);
          rd_load     = re;
          rvalid_next = re;
        end
      end
    endcase
  end

  // Address 0 is hardwired to zero; a write landing on the read address bypasses the array.
  always_comb begin
    rd_a_val = mem[raddr_a];
    rd_b_val = mem[raddr_b];
    if (raddr_a == '0)
      rd_a_val = '0;
    else if (we && (waddr == raddr_a))
      rd_a_val = wdata;
    if (raddr_b == '0)
      rd_b_val = '0;
    else if (we && (waddr == raddr_b))
      rd_b_val = wdata;
  end

  always_ff @(negedge clk) begin
    if (rst_n && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
      rvalid  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      rvalid  <= rvalid_next;
      wr_drop <= wr_drop_next;
      if (rd_load) begin
        rdata_a <= rd_a_val;
        rdata_b <= rd_b_val;
      end
    end
  end

  assign busy = (state_reg == CLEAR);

endmodule
